timer_delay_sched: RTL and testbench
====================================

Name: timer_delay_sched

Overview:
- Hardware scheduler that shares the single interval-timer peripheral among NUM_REQ requesters, each needing a one-shot delay.
- Acts as an Avalon-MM master on the timer's 16-bit register slave:
  - grants one requester round-robin;
  - programs period_l/period_h/control;
  - waits for the timer irq, clears status, then signals completion.
- Sits beside the CPU in the NIOS system; software must not touch the timer while this block owns it.

Parameters:
- NUM_REQ, 4, number of requester channels (2..8).
- DELAY_W, 32, width of the delay request in clk cycles (fixed to 32 to match the timer period width).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- req  in  NUM_REQ  level request per channel; held until done or withdrawn.
- delay  in  NUM_REQ*DELAY_W  packed delay per channel; channel i in bits [i*32+:32].
- done  out  NUM_REQ  one-cycle completion pulse per channel.
- busy  out  1  high whenever the state is not IDLE.
- grant_id  out  3  index of the channel currently being served.
- tmr_address  out  3  timer register address.
- tmr_chipselect  out  1  timer chip select.
- tmr_write_n  out  1  timer write strobe, active-low.
- tmr_writedata  out  16  timer write data.
- tmr_irq  in  1  timer interrupt (timeout_occurred AND ITO).

Behaviour:
- Reset values:
  - done=0, busy=0, grant_id=0;
  - tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0;
  - round-robin pointer=0; state=IDLE.
- All timer accesses are single-cycle writes: chipselect=1, write_n=0 for exactly one cycle. The slave has zero wait states; the block never reads.
- Register map written:
  - addr 0 status: any write clears timeout.
  - addr 1 control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - addr 2 period_l.
  - addr 3 period_h.
- States and transitions:
  - IDLE: if any req, pick the first set bit at or after the rr pointer (wrapping); latch grant_id and latch its delay into dly_q → CHK.
  - CHK:
    - dly_q==0 → DONE (timer untouched).
    - else load period P=dly_q-1 (timer fires P+1 cycles after start) → WR_PL.
  - WR_PL: write addr 2 = P[15:0] → WR_PH.
  - WR_PH: write addr 3 = P[31:16] → GAP.
  - GAP: one idle cycle so the timer's registered force_reload settles → WR_CTL.
  - WR_CTL: write addr 1 = 16'h0005 (START|ITO, one-shot) → WAIT.
  - WAIT:
    - tmr_irq=1 → CLR.
    - req[grant_id]=0 (withdrawn) → ABORT.
    - irq wins if both occur in the same cycle.
  - ABORT: write addr 1 = 16'h0008 (STOP, ITO off) → CLR, with the cancel flag set.
  - CLR: write addr 0 = 0 (clear timeout, drops irq) → DONE; if cancel flag set, go to IDLE instead.
  - DONE:
    - pulse done[grant_id] for 1 cycle;
    - rr pointer = grant_id+1 mod NUM_REQ;
    - → IDLE.
- Latency, start to done: IDLE→CHK→WR_PL→WR_PH→GAP→WR_CTL is 6 cycles, plus the timer delay, plus CLR and DONE.
- The delay value is sampled only at grant; later changes are ignored.
- A requester must drop req on the cycle after done; if it holds req, the next arbitration treats it as a new request.
- Requests arriving during service wait; none are lost because req is level-sensitive.
- reset mid-operation: all outputs return to reset values immediately. The timer may be left running; the first service after reset reprograms it fully.

Decomposition:
- Package timer_sched_pkg:
  - state enum;
  - register address constants: TMR_STATUS=0, TMR_CONTROL=1, TMR_PERIODL=2, TMR_PERIODH=3;
  - control bit constants CTL_ITO/CONT/START/STOP.
- One sub-module: rr_arbiter (NUM_REQ request vector + pointer → one-hot grant + index, combinational).
- The FSM and Avalon driver stay in the top module.

Test Plan:
- req=4'b0001, delay0=100, with a behavioural timer model:
  - write sequence addr2=99, addr3=0, addr1=0x0005, addr0;
  - done[0] is observed 100 timer cycles after the control write.
- delay0=32'h0001_0000:
  - period_l=16'hFFFF, period_h=16'h0000 written in order.
- req=4'b1011, all delays 10:
  - grants in order 0,1,3;
  - then re-asserting all gives order 0,1,3 again, continuing from pointer 0 after wrap.
- delay2=0, req=4'b0100:
  - done[2] pulses 2 cycles after req;
  - no timer write occurs (chipselect stays 0).
- req0 withdrawn during WAIT with delay 1000:
  - writes addr1=0x0008, then addr0;
  - no done pulse; block returns to IDLE.
- reset asserted during WAIT:
  - outputs return to reset values the same cycle;
  - a new request afterwards completes normally with the full 4-write sequence.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the interval-timer delay scheduler:
// FSM states, timer register map and control-register bit positions.
package timer_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK,
        S_WR_PL,
        S_WR_PH,
        S_GAP,
        S_WR_CTL,
        S_WAIT,
        S_ABORT,
        S_CLR,
        S_DONE
    } sched_state_t;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    // Assemble a control-register word from its individual flags.
    function automatic logic [15:0] ctl_word(input logic ito, input logic cont,
                                             input logic start, input logic stop);
        logic [15:0] w;
        w            = '0;
        w[CTL_ITO]   = ito;
        w[CTL_CONT]  = cont;
        w[CTL_START] = start;
        w[CTL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping to the lowest set request when nothing lies above the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         idx,
    output logic               valid
);

    logic [NUM_REQ-1:0] masked;

    assign valid = |req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_chan
            assign masked[gi] = req[gi] && (3'(gi) >= ptr);
            assign grant[gi]  = valid && (idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        idx = '0;
        if (|masked) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (masked[i]) idx = 3'(i);
            end
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req[i]) idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/timer_delay_sched.sv
// Shares one interval-timer peripheral among NUM_REQ one-shot delay requesters,
// driving the timer's 16-bit Avalon-MM slave with single-cycle writes.
module timer_delay_sched
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DELAY_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] delay,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [2:0]                 grant_id,
    output logic [2:0]                 tmr_address,
    output logic                       tmr_chipselect,
    output logic                       tmr_write_n,
    output logic [15:0]                tmr_writedata,
    input  logic                       tmr_irq
);

    sched_state_t       state_reg, state_next;
    logic [2:0]         grant_reg, grant_next;
    logic [2:0]         ptr_reg, ptr_next;
    logic [DELAY_W-1:0] dly_reg, dly_next;
    logic               cancel_reg, cancel_next;

    logic [NUM_REQ-1:0] arb_grant;
    logic [2:0]         arb_idx;
    logic               arb_valid;
    logic [DELAY_W-1:0] delay_arr [NUM_REQ];
    logic [DELAY_W-1:0] sel_delay;
    logic               req_granted;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_chan
            assign delay_arr[gi] = delay[gi*DELAY_W +: DELAY_W];
            assign done[gi]      = (state_reg == S_DONE) && (grant_reg == 3'(gi));
        end
    endgenerate

    always_comb begin
        sel_delay   = '0;
        req_granted = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) sel_delay = sel_delay | delay_arr[i];
            if (grant_reg == 3'(i)) req_granted = req[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            grant_reg  <= '0;
            ptr_reg    <= '0;
            dly_reg    <= '0;
            cancel_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            ptr_reg    <= ptr_next;
            dly_reg    <= dly_next;
            cancel_reg <= cancel_next;
        end
    end

    // dly_reg holds the latched delay until CHK, then the timer period (delay-1).
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        ptr_next    = ptr_reg;
        dly_next    = dly_reg;
        cancel_next = cancel_reg;
        case (state_reg)
            S_IDLE: begin
                cancel_next = 1'b0;
                if (arb_valid) begin
                    grant_next = arb_idx;
                    dly_next   = sel_delay;
                    state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (dly_reg == '0) begin
                    state_next = S_DONE;
                end else begin
                    dly_next   = dly_reg - 1'b1;
                    state_next = S_WR_PL;
                end
            end
            S_WR_PL:  state_next = S_WR_PH;
            S_WR_PH:  state_next = S_GAP;
            S_GAP:    state_next = S_WR_CTL;
            S_WR_CTL: state_next = S_WAIT;
            S_WAIT: begin
                if (tmr_irq) begin
                    state_next = S_CLR;
                end else if (!req_granted) begin
                    state_next = S_ABORT;
                end
            end
            S_ABORT: begin
                cancel_next = 1'b1;
                state_next  = S_CLR;
            end
            S_CLR: state_next = cancel_reg ? S_IDLE : S_DONE;
            S_DONE: begin
                ptr_next   = (grant_reg == 3'(NUM_REQ - 1)) ? 3'd0 : grant_reg + 3'd1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Avalon writes are decoded straight from the state register so a reset
    // drops the bus back to idle in the same cycle.
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_address    = TMR_STATUS;
        tmr_writedata  = '0;
        case (state_reg)
            S_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = TMR_PERIODL;
                tmr_writedata  = dly_reg[15:0];
            end
            S_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_address    = TMR_PERIODH;
                tmr_writedata  = dly_reg[DELAY_W-1:16];
            end
            S_WR_CTL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = TMR_CONTROL;
                tmr_writedata  = ctl_word(1'b1, 1'b0, 1'b1, 1'b0);
            end
            S_ABORT: begin
                tmr_chipselect = 1'b1;
                tmr_address    = TMR_CONTROL;
                tmr_writedata  = ctl_word(1'b0, 1'b0, 1'b0, 1'b1);
            end
            S_CLR: begin
                tmr_chipselect = 1'b1;
                tmr_address    = TMR_STATUS;
                tmr_writedata  = '0;
            end
            default: ;
        endcase
    end

    assign tmr_write_n = ~tmr_chipselect;
    assign busy        = (state_reg != S_IDLE);
    assign grant_id    = grant_reg;

endmodule

// File: tb/tb_timer_delay_sched.sv
// Directed bench for timer_delay_sched with a behavioural interval-timer model
// and a posedge logger of timer writes and done pulses.
module tb_timer_delay_sched;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = '0;
    logic [127:0] delay = '0;
    logic [3:0]   done;
    logic         busy;
    logic [2:0]   grant_id;
    logic [2:0]   tmr_address;
    logic         tmr_chipselect;
    logic         tmr_write_n;
    logic [15:0]  tmr_writedata;
    logic         tmr_irq;

    timer_delay_sched #(
        .NUM_REQ (4),
        .DELAY_W (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .delay          (delay),
        .done           (done),
        .busy           (busy),
        .grant_id       (grant_id),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;

    // One-shot timer: START loads {period_h,period_l}; irq rises period+1 cycles later.
    logic [15:0] t_pl = '0, t_ph = '0;
    logic [31:0] t_cnt = '0;
    logic        t_run = 1'b0, t_to = 1'b0, t_ito = 1'b0;

    always @(posedge clk) begin
        if (t_run) begin
            if (t_cnt == 0) begin
                t_to  <= 1'b1;
                t_run <= 1'b0;
            end else begin
                t_cnt <= t_cnt - 1;
            end
        end
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: t_to <= 1'b0;
                3'd1: begin
                    t_ito <= tmr_writedata[0];
                    if (tmr_writedata[3]) begin
                        t_run <= 1'b0;
                    end else if (tmr_writedata[2]) begin
                        t_run <= 1'b1;
                        t_cnt <= {t_ph, t_pl};
                    end
                end
                3'd2: t_pl <= tmr_writedata;
                3'd3: t_ph <= tmr_writedata;
                default: ;
            endcase
        end
    end

    assign tmr_irq = t_to & t_ito;

    int          cyc = 0;
    logic [2:0]  wa[$];
    logic [15:0] wd[$];
    int          wc[$];
    logic [3:0]  dv[$];
    int          dc[$];

    always @(posedge clk) begin
        if (tmr_chipselect && !tmr_write_n) begin
            wa.push_back(tmr_address);
            wd.push_back(tmr_writedata);
            wc.push_back(cyc);
        end
        if (done != 0) begin
            dv.push_back(done);
            dc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete(); dv.delete(); dc.delete();
    endtask

    task automatic wait_done(input string tag, input int limit, output logic [3:0] d);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (done == 0 && i < limit);
        d = done;
        check({tag, "_seen"}, {31'd0, done != 0}, 32'd1);
    endtask

    task automatic wait_writes(input string tag, input int n, input int limit);
        int i = 0;
        while (wa.size() < n && i < limit) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_writes"}, {31'd0, wa.size() >= n}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int i = 0;
        while (busy && i < limit) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"},  {28'd0, done}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_gid"},   {29'd0, grant_id}, 32'd0);
        check({tag, "_cs"},    {31'd0, tmr_chipselect}, 32'd0);
        check({tag, "_wn"},    {31'd0, tmr_write_n}, 32'd1);
        check({tag, "_addr"},  {29'd0, tmr_address}, 32'd0);
        check({tag, "_wdata"}, {16'd0, tmr_writedata}, 32'd0);
    endtask

    logic [3:0] d;
    logic [3:0] rr_exp [3];
    int         c0;

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b1000};
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Round robin over 0,1,3 twice; pointer wraps back to 0 after channel 3.
        delay = {4{32'd10}};
        for (int p = 0; p < 2; p++) begin
            req = 4'b1011;
            for (int k = 0; k < 3; k++) begin
                wait_done($sformatf("rr_p%0d_k%0d", p, k), 200, d);
                check($sformatf("rr_p%0d_grant%0d", p, k), {28'd0, d}, {28'd0, rr_exp[k]});
                req = req & ~d;
            end
            @(negedge clk);
        end
        wait_idle("rr", 20);

        // Delay 100 on channel 0: period 99, full write sequence.
        clear_logs();
        delay[31:0] = 32'd100;
        req = 4'b0001;
        wait_done("d100", 400, d);
        req = 4'b0000;
        check("d100_done", {28'd0, d}, 32'h1);
        check("d100_gid", {29'd0, grant_id}, 32'd0);
        @(negedge clk);
        check("d100_pulse_len", {28'd0, done}, 32'd0);
        check("d100_nwr", wa.size(), 32'd4);
        check("d100_a0", {29'd0, wa[0]}, 32'd2);
        check("d100_d0", {16'd0, wd[0]}, 32'd99);
        check("d100_a1", {29'd0, wa[1]}, 32'd3);
        check("d100_d1", {16'd0, wd[1]}, 32'd0);
        check("d100_a2", {29'd0, wa[2]}, 32'd1);
        check("d100_d2", {16'd0, wd[2]}, 32'h5);
        check("d100_a3", {29'd0, wa[3]}, 32'd0);
        check("d100_d3", {16'd0, wd[3]}, 32'd0);
        // control-write cycle, 100 timer cycles, then WAIT, CLR, DONE
        check("d100_latency", 32'(dc[0] - wc[2]), 32'd103);

        // Delay 0x10000: period split across the 16-bit halves; then withdrawn.
        clear_logs();
        delay[31:0] = 32'h0001_0000;
        req = 4'b0001;
        wait_writes("big", 3, 50);
        check("big_a0", {29'd0, wa[0]}, 32'd2);
        check("big_d0", {16'd0, wd[0]}, 32'hFFFF);
        check("big_a1", {29'd0, wa[1]}, 32'd3);
        check("big_d1", {16'd0, wd[1]}, 32'h0000);
        req = 4'b0000;
        wait_idle("big", 20);
        check("big_nodone", dv.size(), 32'd0);

        // Zero delay on channel 2 finishes without touching the timer.
        clear_logs();
        delay[95:64] = 32'd0;
        c0 = cyc;
        req = 4'b0100;
        wait_done("zero", 20, d);
        req = 4'b0000;
        check("zero_done", {28'd0, d}, 32'h4);
        check("zero_gid", {29'd0, grant_id}, 32'd2);
        @(negedge clk);
        check("zero_latency", 32'(dc[0] - c0), 32'd2);
        check("zero_nwr", wa.size(), 32'd0);

        // Channel 0 withdraws during WAIT: STOP write, status clear, no done.
        clear_logs();
        delay[31:0] = 32'd1000;
        req = 4'b0001;
        wait_writes("wd", 3, 50);
        check("wd_d0", {16'd0, wd[0]}, 32'h3E7);
        repeat (10) @(negedge clk);
        req = 4'b0000;
        wait_idle("wd", 20);
        check("wd_nwr", wa.size(), 32'd5);
        check("wd_a3", {29'd0, wa[3]}, 32'd1);
        check("wd_d3", {16'd0, wd[3]}, 32'h8);
        check("wd_a4", {29'd0, wa[4]}, 32'd0);
        check("wd_d4", {16'd0, wd[4]}, 32'd0);
        check("wd_nodone", dv.size(), 32'd0);

        // Reset while channel 1 waits on the timer.
        clear_logs();
        delay[63:32] = 32'd500;
        req = 4'b0010;
        wait_writes("rw", 3, 50);
        repeat (5) @(negedge clk);
        check("rw_gid_before", {29'd0, grant_id}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rw");
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        clear_logs();
        delay[31:0] = 32'd20;
        req = 4'b0001;
        wait_done("post", 100, d);
        req = 4'b0000;
        check("post_done", {28'd0, d}, 32'h1);
        @(negedge clk);
        check("post_nwr", wa.size(), 32'd4);
        check("post_a0", {29'd0, wa[0]}, 32'd2);
        check("post_d0", {16'd0, wd[0]}, 32'd19);
        check("post_a1", {29'd0, wa[1]}, 32'd3);
        check("post_a2", {29'd0, wa[2]}, 32'd1);
        check("post_d2", {16'd0, wd[2]}, 32'h5);
        check("post_a3", {29'd0, wa[3]}, 32'd0);
        check("post_latency", 32'(dc[0] - wc[2]), 32'd23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
